vga_timing_gen: RTL and testbench

Pixel-timing generator that produces the raster position and sync strobes consumed by the test-pattern/digit-rendering stage in the Basys3 VGA adaptors. It counts pixels and lines for 640x480@60 Hz and emits hsync/vsync, display_on and the hpos/vpos coordinates. It also emits frame and line markers and a frame counter for animation. A clock-enable input lets it run either on a prescaled 25 MHz clock or on the 100 MHz board clock with a 1-in-4 enable.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/axis_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 Hz raster timing generator.
// Holds the default porch/sync geometry and the derived totals and sync windows.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/axis_counter.sv
// One raster axis: wrapping position counter plus registered visible and sync-window flags.
// Flags track the next count on every enabled pixel so they stay aligned with o_count.
module axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W         = POS_W,
  parameter int unsigned TOTAL     = VGA_H_TOTAL,
  parameter int unsigned ACT_END   = VGA_H_DISPLAY,
  parameter int unsigned WIN_START = VGA_H_SYNC_START,
  parameter int unsigned WIN_END   = VGA_H_SYNC_END
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_in_win
);

  localparam logic [W-1:0] L_LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] L_ACT_END   = W'(ACT_END);
  localparam logic [W-1:0] L_WIN_START = W'(WIN_START);
  localparam logic [W-1:0] L_WIN_END   = W'(WIN_END);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_at_last;
  logic         r_active;
  logic         r_in_win;

  always_comb begin
    w_at_last = (r_count == L_LAST);
    w_next    = r_count;
    if (i_inc) begin
      w_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  // Flags refresh on every pixel enable (not only on increment) so the vertical
  // flags become valid on the very first enabled edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_in_win <= 1'b0;
    end else begin
      r_count <= w_next;
      if (i_en) begin
        r_active <= (w_next < L_ACT_END);
        r_in_win <= (w_next >= L_WIN_START) && (w_next <= L_WIN_END);
      end
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = i_inc & w_at_last;
  assign o_active = r_active;
  assign o_in_win = r_in_win;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync strobes, display enable,
// line/frame start pulses and a free-running frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [POS_W-1:0]  hpos,
  output logic [POS_W-1:0]  vpos,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;

  logic              w_h_wrap;
  logic              w_h_active;
  logic              w_h_in_win;
  logic              w_v_inc;
  logic              w_v_wrap;
  logic              w_v_active;
  logic              w_v_in_win;
  logic              r_line_start;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_count;

  axis_counter #(
    .W        (POS_W),
    .TOTAL    (H_TOTAL),
    .ACT_END  (H_DISPLAY),
    .WIN_START(H_SYNC_START),
    .WIN_END  (H_SYNC_START + H_SYNC - 1)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (clk_en),
    .i_inc   (clk_en),
    .o_count (hpos),
    .o_wrap  (w_h_wrap),
    .o_active(w_h_active),
    .o_in_win(w_h_in_win)
  );

  assign w_v_inc = w_h_wrap & clk_en;

  axis_counter #(
    .W        (POS_W),
    .TOTAL    (V_TOTAL),
    .ACT_END  (V_DISPLAY),
    .WIN_START(V_SYNC_START),
    .WIN_END  (V_SYNC_START + V_SYNC - 1)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (clk_en),
    .i_inc   (w_v_inc),
    .o_count (vpos),
    .o_wrap  (w_v_wrap),
    .o_active(w_v_active),
    .o_in_win(w_v_in_win)
  );

  // Strobes are rewritten every clk so they last exactly one clk even when clk_en is sparse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap & w_v_wrap;
      if (w_h_wrap & w_v_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign hsync       = sync_level(w_h_in_win, SYNC_POL);
  assign vsync       = sync_level(w_v_in_win, SYNC_POL);
  assign display_on  = w_h_active & w_v_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size geometry for line timing, plus two
// reduced-geometry instances (15x8 raster, active-low and active-high sync) for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic clk_en;

  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [9:0] hpos, vpos;
  logic [7:0] frame_count;

  logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_frame_count;

  logic       p_hsync, p_vsync, p_display_on, p_line_start, p_frame_start;
  logic [9:0] p_hpos, p_vpos;
  logic [7:0] p_frame_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0), .FCNT_W(8)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hsync(s_hsync), .vsync(s_vsync), .display_on(s_display_on),
    .hpos(s_hpos), .vpos(s_vpos),
    .line_start(s_line_start), .frame_start(s_frame_start), .frame_count(s_frame_count)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1), .FCNT_W(8)
  ) u_pos (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hsync(p_hsync), .vsync(p_vsync), .display_on(p_display_on),
    .hpos(p_hpos), .vpos(p_vpos),
    .line_start(p_line_start), .frame_start(p_frame_start), .frame_count(p_frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clk_en  = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned hs_cnt, hs_first, hs_last, de_cnt, ls_cnt, fs_cnt, vs_cnt, ph_cnt, pv_cnt, err, k;
    int unsigned eh, ev;

    // Reset state
    reset_n = 1'b0;
    clk_en  = 1'b1;
    repeat (3) tick();
    check_eq("rst_hpos",        32'(hpos),          32'd0);
    check_eq("rst_vpos",        32'(vpos),          32'd0);
    check_eq("rst_hsync",       32'(hsync),         32'd1);
    check_eq("rst_vsync",       32'(vsync),         32'd1);
    check_eq("rst_display_on",  32'(display_on),    32'd0);
    check_eq("rst_line_start",  32'(line_start),    32'd0);
    check_eq("rst_frame_start", 32'(frame_start),   32'd0);
    check_eq("rst_frame_count", 32'(frame_count),   32'd0);
    check_eq("rst_pos_hsync",   32'(p_hsync),       32'd0);
    check_eq("rst_pos_vsync",   32'(p_vsync),       32'd0);
    check_eq("rst_pos_de",      32'(p_display_on),  32'd0);
    check_eq("rst_pos_hpos",    32'(p_hpos),        32'd0);
    check_eq("rst_pos_vpos",    32'(p_vpos),        32'd0);
    check_eq("rst_pos_ls",      32'(p_line_start),  32'd0);
    check_eq("rst_pos_fs",      32'(p_frame_start), 32'd0);
    check_eq("rst_pos_fcnt",    32'(p_frame_count), 32'd0);

    // One full 800-pixel line on the full-size instance
    reset_n = 1'b1;
    hs_cnt = 0; hs_first = 0; hs_last = 0; de_cnt = 0; ls_cnt = 0; err = 0;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (32'(hpos) != 32'(i % 800)) err++;
      if (!hsync) begin
        if (hs_cnt == 0) hs_first = 32'(hpos);
        hs_last = 32'(hpos);
        hs_cnt++;
      end
      if (display_on) de_cnt++;
      if (line_start) ls_cnt++;
      if (i == 1) begin
        check_eq("first_edge_hpos", 32'(hpos),       32'd1);
        check_eq("first_edge_vpos", 32'(vpos),       32'd0);
        check_eq("first_edge_de",   32'(display_on), 32'd1);
      end
    end
    check_eq("line_hpos_seq",   err,             32'd0);
    check_eq("line_hsync_len",  hs_cnt,          32'd96);
    check_eq("line_hsync_from", hs_first,        32'd656);
    check_eq("line_hsync_to",   hs_last,         32'd751);
    check_eq("line_de_count",   de_cnt,          32'd640);
    check_eq("line_ls_count",   ls_cnt,          32'd1);
    check_eq("line_wrap_ls",    32'(line_start), 32'd1);
    check_eq("line_wrap_hpos",  32'(hpos),       32'd0);
    check_eq("line_wrap_vpos",  32'(vpos),       32'd1);

    // One full frame of the 15x8 raster (120 enabled clks)
    do_reset();
    vs_cnt = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; ph_cnt = 0; pv_cnt = 0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (!s_vsync) vs_cnt++;
      if (s_display_on) de_cnt++;
      if (s_line_start) ls_cnt++;
      if (s_frame_start) fs_cnt++;
      if (p_hsync) ph_cnt++;
      if (p_vsync) pv_cnt++;
    end
    check_eq("frm_vsync_len",   vs_cnt,             32'd30);
    check_eq("frm_de_count",    de_cnt,             32'd32);
    check_eq("frm_ls_count",    ls_cnt,             32'd8);
    check_eq("frm_fs_count",    fs_cnt,             32'd1);
    check_eq("frm_pos_hsync",   ph_cnt,             32'd24);
    check_eq("frm_pos_vsync",   pv_cnt,             32'd30);
    check_eq("frm_wrap_fs",     32'(s_frame_start), 32'd1);
    check_eq("frm_wrap_ls",     32'(s_line_start),  32'd1);
    check_eq("frm_wrap_fcnt",   32'(s_frame_count), 32'd1);
    check_eq("frm_wrap_pos",    32'({s_vpos, s_hpos}), 32'd0);
    clk_en = 1'b0;
    tick();
    check_eq("fs_clears_no_en", 32'(s_frame_start), 32'd0);
    check_eq("ls_clears_no_en", 32'(s_line_start),  32'd0);
    check_eq("hold_hpos",       32'(s_hpos),        32'd0);
    check_eq("hold_fcnt",       32'(s_frame_count), 32'd1);

    // 1-in-4 pixel enable: same position sequence, strobes still one clk wide
    do_reset();
    k = 0; err = 0; ls_cnt = 0; fs_cnt = 0;
    for (int c = 0; c < 480; c++) begin
      clk_en = ((c % 4) == 3);
      tick();
      if (clk_en) k++;
      eh = k % 15;
      ev = (k / 15) % 8;
      if (32'(s_hpos) != eh) err++;
      if (32'(s_vpos) != ev) err++;
      if (s_hsync != !(eh >= 10 && eh <= 12)) err++;
      if (s_vsync != !(ev >= 5 && ev <= 6)) err++;
      if (s_display_on != (k > 0 && eh < 8 && ev < 4)) err++;
      if (s_line_start != (clk_en && eh == 0)) err++;
      if (s_frame_start != (clk_en && (k % 120) == 0)) err++;
      if (s_line_start) ls_cnt++;
      if (s_frame_start) fs_cnt++;
    end
    check_eq("en4_seq_errors", err,                32'd0);
    check_eq("en4_ls_clks",    ls_cnt,             32'd8);
    check_eq("en4_fs_clks",    fs_cnt,             32'd1);
    check_eq("en4_fcnt",       32'(s_frame_count), 32'd1);

    // Asynchronous reset while inside both sync windows
    do_reset();
    repeat (700) tick();
    check_eq("mid_hpos",       32'(hpos),          32'd700);
    check_eq("mid_vpos",       32'(vpos),          32'd0);
    check_eq("mid_hsync",      32'(hsync),         32'd0);
    check_eq("mid_s_hpos",     32'(s_hpos),        32'd10);
    check_eq("mid_s_vpos",     32'(s_vpos),        32'd6);
    check_eq("mid_s_hsync",    32'(s_hsync),       32'd0);
    check_eq("mid_s_vsync",    32'(s_vsync),       32'd0);
    check_eq("mid_s_fcnt",     32'(s_frame_count), 32'd5);
    check_eq("mid_p_hsync",    32'(p_hsync),       32'd1);
    check_eq("mid_p_vsync",    32'(p_vsync),       32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_hpos",      32'(hpos),          32'd0);
    check_eq("arst_vpos",      32'(vpos),          32'd0);
    check_eq("arst_hsync",     32'(hsync),         32'd1);
    check_eq("arst_vsync",     32'(vsync),         32'd1);
    check_eq("arst_de",        32'(display_on),    32'd0);
    check_eq("arst_s_pos",     32'({s_vpos, s_hpos}), 32'd0);
    check_eq("arst_s_hsync",   32'(s_hsync),       32'd1);
    check_eq("arst_s_vsync",   32'(s_vsync),       32'd1);
    check_eq("arst_s_fcnt",    32'(s_frame_count), 32'd0);
    check_eq("arst_s_ls",      32'(s_line_start),  32'd0);
    check_eq("arst_p_hsync",   32'(p_hsync),       32'd0);
    check_eq("arst_p_vsync",   32'(p_vsync),       32'd0);

    // 256 frames: frame_count wraps 255 -> 0 together with frame_start
    tick();
    reset_n = 1'b1;
    clk_en  = 1'b1;
    err = 0;
    for (int f = 1; f <= 256; f++) begin
      repeat (120) tick();
      if (!s_frame_start || 32'(s_frame_count) != 32'(f % 256)) err++;
      if (f == 255) check_eq("fcnt_at_255", 32'(s_frame_count), 32'd255);
    end
    check_eq("fcnt_seq_errors", err,                32'd0);
    check_eq("fcnt_wrap_value", 32'(s_frame_count), 32'd0);
    check_eq("fcnt_wrap_fs",    32'(s_frame_start), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
